// File: rtl/ecc_point_add_pkg.sv
// Shared types and modular-arithmetic helpers for the elliptic-curve point adder.
package ecc_point_add_pkg;

  localparam int unsigned MIN_W  = 5;
  localparam int unsigned MAX_W  = 7;
  localparam int unsigned WIDE_W = 2 * MAX_W + 2;

  // Helpers operate at the widest legal operand width; narrower operands are zero-extended.
  typedef logic [MAX_W-1:0]  elem_t;
  typedef logic [WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIFF = 3'd1,
    ST_INV  = 3'd2,
    ST_LAM  = 3'd3,
    ST_X3   = 3'd4,
    ST_Y3   = 3'd5,
    ST_OUT  = 3'd6
  } state_t;

  // Operand widths supported by the inverse IP.
  function automatic bit ip_width_legal(input int unsigned w);
    return (w >= MIN_W) && (w <= MAX_W);
  endfunction

  // (a - b) mod p for a, b < p: form a - b + p one bit wider, then subtract p once if needed.
  function automatic elem_t mod_sub(input elem_t a, input elem_t b, input elem_t p);
    logic [MAX_W:0] t;
    t = {1'b0, a} + {1'b0, p} - {1'b0, b};
    if (t >= {1'b0, p}) begin
      t = t - {1'b0, p};
    end
    return elem_t'(t);
  endfunction

  // x mod p for a wide product or polynomial value.
  function automatic elem_t mod_reduce(input wide_t x, input elem_t p);
    wide_t r;
    r = x % wide_t'(p);
    return elem_t'(r);
  endfunction

endpackage

// File: rtl/mod_inv_ip.sv
// Combinational modular inverse: OUT_INV * IN_1 == 1 (mod IN_2), or 0 when no inverse exists.
module mod_inv_ip #(
  parameter int unsigned IP_WIDTH = 6
) (
  input  logic [IP_WIDTH-1:0] IN_1,
  input  logic [IP_WIDTH-1:0] IN_2,
  output logic [IP_WIDTH-1:0] OUT_INV
);

  localparam int unsigned PW = 2 * IP_WIDTH;
  localparam int unsigned N  = 1 << IP_WIDTH;

  // Search all residues below the modulus for the unique inverse.
  always_comb begin
    OUT_INV = '0;
    for (int unsigned c = 1; c < N; c++) begin
      if ((IP_WIDTH'(c) < IN_2) &&
          (((PW'(IN_1) * PW'(c)) % PW'(IN_2)) == PW'(1))) begin
        OUT_INV = IP_WIDTH'(c);
      end
    end
  end

endmodule

// File: rtl/ecc_point_add.sv
// Sequential affine point adder/doubler over GF(p) with a fixed six-cycle latency.
module ecc_point_add #(
  parameter int unsigned IP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IP_WIDTH-1:0] in_x1,
  input  logic [IP_WIDTH-1:0] in_y1,
  input  logic [IP_WIDTH-1:0] in_x2,
  input  logic [IP_WIDTH-1:0] in_y2,
  input  logic [IP_WIDTH-1:0] in_prime,
  input  logic [IP_WIDTH-1:0] in_a,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_x,
  output logic [IP_WIDTH-1:0] out_y,
  output logic                out_inf
);

  import ecc_point_add_pkg::*;

  localparam int unsigned W  = IP_WIDTH;
  localparam int unsigned PW = 2 * IP_WIDTH;
  localparam int unsigned TW = 2 * IP_WIDTH + 2;

  if (!ip_width_legal(IP_WIDTH)) begin : g_bad_width
    $error("ecc_point_add: IP_WIDTH must be 5, 6 or 7");
  end

  state_t state;
  state_t state_nxt;

  // Control decoded from the current state.
  logic accept;
  logic ld_diff;
  logic ld_inv;
  logic ld_lam;
  logic ld_x3;
  logic ld_y3;
  logic ld_out;

  // Latched operands and flags.
  logic [W-1:0] x1;
  logic [W-1:0] y1;
  logic [W-1:0] x2;
  logic [W-1:0] y2;
  logic [W-1:0] p;
  logic [W-1:0] a;
  logic         dbl;
  logic         inf;

  // Pipeline-of-states intermediates.
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic [W-1:0] inv;
  logic [W-1:0] lam;
  logic [W-1:0] x3;
  logic [W-1:0] y3;

  // Combinational datapath.
  logic          dbl_in_c;
  logic          inf_in_c;
  elem_t         pe;
  elem_t         x1e;
  elem_t         y1e;
  elem_t         x2e;
  elem_t         y2e;
  logic [PW-1:0] x1_sq_c;
  logic [TW-1:0] poly_c;
  logic [W:0]    two_y1_c;
  logic [W-1:0]  num_dbl_c;
  logic [W-1:0]  den_dbl_c;
  logic [W-1:0]  num_add_c;
  logic [W-1:0]  den_add_c;
  logic [W-1:0]  inv_c;
  logic [PW-1:0] lam_prod_c;
  logic [W-1:0]  lam_c;
  logic [PW-1:0] lam_sq_c;
  elem_t         lam_sq_mod_c;
  logic [W-1:0]  x3_c;
  logic [W-1:0]  dx_c;
  logic [PW-1:0] y_prod_c;
  logic [W-1:0]  y3_c;

  assign dbl_in_c = (in_x1 == in_x2) && (in_y1 == in_y2);
  assign inf_in_c = ((in_x1 == in_x2) && !dbl_in_c) || (dbl_in_c && (in_y1 == '0));

  assign pe  = elem_t'(p);
  assign x1e = elem_t'(x1);
  assign y1e = elem_t'(y1);
  assign x2e = elem_t'(x2);
  assign y2e = elem_t'(y2);

  // Slope numerator/denominator for doubling and for addition.
  assign x1_sq_c   = PW'(x1) * PW'(x1);
  assign poly_c    = TW'(3) * TW'(x1_sq_c) + TW'(a);
  assign two_y1_c  = {y1, 1'b0};
  assign num_dbl_c = W'(mod_reduce(wide_t'(poly_c), pe));
  assign den_dbl_c = W'(mod_reduce(wide_t'(two_y1_c), pe));
  assign num_add_c = W'(mod_sub(y2e, y1e, pe));
  assign den_add_c = W'(mod_sub(x2e, x1e, pe));

  mod_inv_ip #(
    .IP_WIDTH(IP_WIDTH)
  ) u_inv (
    .IN_1   (den),
    .IN_2   (p),
    .OUT_INV(inv_c)
  );

  // lambda, x3 and y3 each consume only values registered in earlier states.
  assign lam_prod_c   = PW'(num) * PW'(inv);
  assign lam_c        = W'(mod_reduce(wide_t'(lam_prod_c), pe));
  assign lam_sq_c     = PW'(lam) * PW'(lam);
  assign lam_sq_mod_c = mod_reduce(wide_t'(lam_sq_c), pe);
  assign x3_c         = W'(mod_sub(mod_sub(lam_sq_mod_c, x1e, pe), x2e, pe));
  assign dx_c         = W'(mod_sub(x1e, elem_t'(x3), pe));
  assign y_prod_c     = PW'(lam) * PW'(dx_c);
  assign y3_c         = W'(mod_sub(mod_reduce(wide_t'(y_prod_c), pe), y1e, pe));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed walk through the arithmetic steps once an input is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_DIFF;
      ST_DIFF: state_nxt = ST_INV;
      ST_INV:  state_nxt = ST_LAM;
      ST_LAM:  state_nxt = ST_X3;
      ST_X3:   state_nxt = ST_Y3;
      ST_Y3:   state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State decode; the IDLE cycle that carries out_valid still counts as busy.
  always_comb begin
    accept  = 1'b0;
    ld_diff = 1'b0;
    ld_inv  = 1'b0;
    ld_lam  = 1'b0;
    ld_x3   = 1'b0;
    ld_y3   = 1'b0;
    ld_out  = 1'b0;
    case (state)
      ST_IDLE: accept  = in_valid && !out_valid;
      ST_DIFF: ld_diff = 1'b1;
      ST_INV:  ld_inv  = 1'b1;
      ST_LAM:  ld_lam  = 1'b1;
      ST_X3:   ld_x3   = 1'b1;
      ST_Y3:   ld_y3   = 1'b1;
      ST_OUT:  ld_out  = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers; outputs return to zero outside the result cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
      p         <= '0;
      a         <= '0;
      dbl       <= 1'b0;
      inf       <= 1'b0;
      num       <= '0;
      den       <= '0;
      inv       <= '0;
      lam       <= '0;
      x3        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_inf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_inf   <= 1'b0;
      if (accept) begin
        x1  <= in_x1;
        y1  <= in_y1;
        x2  <= in_x2;
        y2  <= in_y2;
        p   <= in_prime;
        a   <= in_a;
        dbl <= dbl_in_c;
        inf <= inf_in_c;
      end
      if (ld_diff) begin
        num <= dbl ? num_dbl_c : num_add_c;
        den <= dbl ? den_dbl_c : den_add_c;
      end
      if (ld_inv) inv <= inv_c;
      if (ld_lam) lam <= lam_c;
      if (ld_x3)  x3  <= x3_c;
      if (ld_y3)  y3  <= y3_c;
      if (ld_out) begin
        out_valid <= 1'b1;
        out_inf   <= inf;
        out_x     <= inf ? '0 : x3;
        out_y     <= inf ? '0 : y3;
      end
    end
  end

endmodule

// File: tb/tb_ecc_point_add.sv
// Directed and model-checked bench for ecc_point_add at IP_WIDTH 5, 6 and 7 in parallel.
module tb_ecc_point_add;

  localparam int P = 17;
  localparam int A = 2;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] x1, y1, x2, y2, pr, ca;

  logic       ov5, oi5, ov6, oi6, ov7, oi7;
  logic [4:0] ox5, oy5;
  logic [5:0] ox6, oy6;
  logic [6:0] ox7, oy7;

  logic       ov [3];
  logic       oi [3];
  logic [6:0] ox [3];
  logic [6:0] oy [3];

  assign ov[0] = ov5;
  assign ov[1] = ov6;
  assign ov[2] = ov7;
  assign oi[0] = oi5;
  assign oi[1] = oi6;
  assign oi[2] = oi7;
  assign ox[0] = {2'b00, ox5};
  assign ox[1] = {1'b0, ox6};
  assign ox[2] = ox7;
  assign oy[0] = {2'b00, oy5};
  assign oy[1] = {1'b0, oy6};
  assign oy[2] = oy7;

  int errors = 0;
  int checks = 0;

  int         cap_lat  [3];
  int         cap_cnt  [3];
  int         cap_leak [3];
  logic [6:0] cap_x    [3];
  logic [6:0] cap_y    [3];
  logic       cap_inf  [3];

  int px[$];
  int py[$];

  always #5 clk = ~clk;

  ecc_point_add #(.IP_WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_x1(x1[4:0]), .in_y1(y1[4:0]), .in_x2(x2[4:0]), .in_y2(y2[4:0]),
    .in_prime(pr[4:0]), .in_a(ca[4:0]),
    .out_valid(ov5), .out_x(ox5), .out_y(oy5), .out_inf(oi5)
  );

  ecc_point_add #(.IP_WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_x1(x1[5:0]), .in_y1(y1[5:0]), .in_x2(x2[5:0]), .in_y2(y2[5:0]),
    .in_prime(pr[5:0]), .in_a(ca[5:0]),
    .out_valid(ov6), .out_x(ox6), .out_y(oy6), .out_inf(oi6)
  );

  ecc_point_add #(.IP_WIDTH(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_x1(x1), .in_y1(y1), .in_x2(x2), .in_y2(y2),
    .in_prime(pr), .in_a(ca),
    .out_valid(ov7), .out_x(ox7), .out_y(oy7), .out_inf(oi7)
  );

  function automatic int md(input int v);
    return ((v % P) + P) % P;
  endfunction

  // Fermat inverse v^(p-2) mod p.
  function automatic int inv_p(input int v);
    int r;
    r = 1;
    for (int k = 0; k < P - 2; k++) r = md(r * v);
    return r;
  endfunction

  // Textbook affine group law on y^2 = x^3 + A x + B over GF(17).
  task automatic ref_add(input int ax1, input int ay1, input int ax2, input int ay2,
                         output int rx, output int ry, output bit rinf);
    int lam;
    rx = 0;
    ry = 0;
    rinf = 1'b0;
    if ((ax1 == ax2) && ((ay1 != ay2) || (ay1 == 0))) begin
      rinf = 1'b1;
    end else begin
      if (ax1 == ax2) lam = md(md(3 * ax1 * ax1 + A) * inv_p(md(2 * ay1)));
      else            lam = md(md(ay2 - ay1) * inv_p(md(ax2 - ax1)));
      rx = md(lam * lam - ax1 - ax2);
      ry = md(lam * (ax1 - rx) - ay1);
    end
  endtask

  // Issue one input, then record what each DUT shows for `window` cycles.
  task automatic run_op(input int ix1, input int iy1, input int ix2, input int iy2,
                        input int window);
    @(posedge clk); #1;
    x1 = 7'(ix1); y1 = 7'(iy1); x2 = 7'(ix2); y2 = 7'(iy2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cap_lat[d] = -1; cap_cnt[d] = 0; cap_leak[d] = 0;
      cap_x[d] = '0; cap_y[d] = '0; cap_inf[d] = 1'b0;
    end
    for (int c = 1; c <= window; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (ov[d] === 1'b1) begin
          if (cap_cnt[d] == 0) begin
            cap_lat[d] = c; cap_x[d] = ox[d]; cap_y[d] = oy[d]; cap_inf[d] = oi[d];
          end
          cap_cnt[d]++;
        end else if ((ox[d] !== 7'd0) || (oy[d] !== 7'd0) || (oi[d] !== 1'b0)) begin
          cap_leak[d]++;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_valid w%0d: got %b want 0", 5+d, ov[d]); end
      checks++; if (ox[d] !== 7'd0) begin errors++; $display("FAIL reset_x w%0d: got %0d want 0", 5+d, ox[d]); end
      checks++; if (oy[d] !== 7'd0) begin errors++; $display("FAIL reset_y w%0d: got %0d want 0", 5+d, oy[d]); end
      checks++; if (oi[d] !== 1'b0) begin errors++; $display("FAIL reset_inf w%0d: got %b want 0", 5+d, oi[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    run_op(5, 1, 6, 3, 10);
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_lat[d] !== 6)  begin errors++; $display("FAIL add_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_cnt[d] !== 1)  begin errors++; $display("FAIL add_count w%0d: got %0d want 1", 5+d, cap_cnt[d]); end
      checks++; if (cap_x[d] !== 7'd10) begin errors++; $display("FAIL add_x w%0d: got %0d want 10", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd6)  begin errors++; $display("FAIL add_y w%0d: got %0d want 6", 5+d, cap_y[d]); end
      checks++; if (cap_inf[d] !== 1'b0) begin errors++; $display("FAIL add_inf w%0d: got %b want 0", 5+d, cap_inf[d]); end
      checks++; if (cap_leak[d] !== 0) begin errors++; $display("FAIL add_idle_zero w%0d: got %0d want 0", 5+d, cap_leak[d]); end
    end
  endtask

  task automatic test_double;
    run_op(5, 1, 5, 1, 10);
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_lat[d] !== 6)  begin errors++; $display("FAIL dbl_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_cnt[d] !== 1)  begin errors++; $display("FAIL dbl_count w%0d: got %0d want 1", 5+d, cap_cnt[d]); end
      checks++; if (cap_x[d] !== 7'd6) begin errors++; $display("FAIL dbl_x w%0d: got %0d want 6", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd3) begin errors++; $display("FAIL dbl_y w%0d: got %0d want 3", 5+d, cap_y[d]); end
      checks++; if (cap_inf[d] !== 1'b0) begin errors++; $display("FAIL dbl_inf w%0d: got %b want 0", 5+d, cap_inf[d]); end
      checks++; if (cap_leak[d] !== 0) begin errors++; $display("FAIL dbl_idle_zero w%0d: got %0d want 0", 5+d, cap_leak[d]); end
    end
  endtask

  task automatic test_inverse;
    run_op(5, 1, 5, 16, 10);
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_lat[d] !== 6)  begin errors++; $display("FAIL neg_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_cnt[d] !== 1)  begin errors++; $display("FAIL neg_count w%0d: got %0d want 1", 5+d, cap_cnt[d]); end
      checks++; if (cap_x[d] !== 7'd0) begin errors++; $display("FAIL neg_x w%0d: got %0d want 0", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd0) begin errors++; $display("FAIL neg_y w%0d: got %0d want 0", 5+d, cap_y[d]); end
      checks++; if (cap_inf[d] !== 1'b1) begin errors++; $display("FAIL neg_inf w%0d: got %b want 1", 5+d, cap_inf[d]); end
    end
  endtask

  task automatic test_double_y0;
    run_op(3, 0, 3, 0, 10);
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_lat[d] !== 6)  begin errors++; $display("FAIL dbl0_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_x[d] !== 7'd0) begin errors++; $display("FAIL dbl0_x w%0d: got %0d want 0", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd0) begin errors++; $display("FAIL dbl0_y w%0d: got %0d want 0", 5+d, cap_y[d]); end
      checks++; if (cap_inf[d] !== 1'b1) begin errors++; $display("FAIL dbl0_inf w%0d: got %b want 1", 5+d, cap_inf[d]); end
    end
  endtask

  // Second strobe two cycles into a calculation must be dropped.
  task automatic test_busy;
    @(posedge clk); #1;
    x1 = 7'd5; y1 = 7'd1; x2 = 7'd6; y2 = 7'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cap_lat[d] = -1; cap_cnt[d] = 0; cap_x[d] = '0; cap_y[d] = '0;
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (ov[d] === 1'b1) begin
          if (cap_cnt[d] == 0) begin cap_lat[d] = c; cap_x[d] = ox[d]; cap_y[d] = oy[d]; end
          cap_cnt[d]++;
        end
      end
      if (c == 1) begin
        x1 = 7'd5; y1 = 7'd1; x2 = 7'd5; y2 = 7'd1;
        in_valid = 1'b1;
      end
      if (c == 2) in_valid = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_cnt[d] !== 1)   begin errors++; $display("FAIL busy_count w%0d: got %0d want 1", 5+d, cap_cnt[d]); end
      checks++; if (cap_lat[d] !== 6)   begin errors++; $display("FAIL busy_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_x[d] !== 7'd10) begin errors++; $display("FAIL busy_x w%0d: got %0d want 10", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd6)  begin errors++; $display("FAIL busy_y w%0d: got %0d want 6", 5+d, cap_y[d]); end
    end
  endtask

  // Reset while in X3 aborts the calculation.
  task automatic test_reset_mid;
    int cnt [3];
    @(posedge clk); #1;
    x1 = 7'd5; y1 = 7'd1; x2 = 7'd6; y2 = 7'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL rstmid_valid w%0d: got %b want 0", 5+d, ov[d]); end
      checks++; if (ox[d] !== 7'd0 || oy[d] !== 7'd0) begin errors++; $display("FAIL rstmid_xy w%0d: got %0d,%0d want 0,0", 5+d, ox[d], oy[d]); end
      cnt[d] = 0;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) if (ov[d] === 1'b1) cnt[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      checks++; if (cnt[d] !== 0) begin errors++; $display("FAIL rstmid_no_valid w%0d: got %0d want 0", 5+d, cnt[d]); end
    end
  endtask

  task automatic test_after_reset;
    run_op(5, 1, 6, 3, 10);
    for (int d = 0; d < 3; d++) begin
      checks++; if (cap_lat[d] !== 6)   begin errors++; $display("FAIL post_rst_latency w%0d: got %0d want 6", 5+d, cap_lat[d]); end
      checks++; if (cap_x[d] !== 7'd10) begin errors++; $display("FAIL post_rst_x w%0d: got %0d want 10", 5+d, cap_x[d]); end
      checks++; if (cap_y[d] !== 7'd6)  begin errors++; $display("FAIL post_rst_y w%0d: got %0d want 6", 5+d, cap_y[d]); end
    end
  endtask

  // Random on-curve pairs issued the cycle after each result.
  task automatic test_random;
    int i, j, ex, ey;
    bit ei;
    for (int it = 0; it < 1000; it++) begin
      i = int'($urandom_range(0, px.size() - 1));
      j = ($urandom_range(0, 7) == 0) ? i : int'($urandom_range(0, px.size() - 1));
      ref_add(px[i], py[i], px[j], py[j], ex, ey, ei);
      run_op(px[i], py[i], px[j], py[j], 6);
      for (int d = 0; d < 3; d++) begin
        checks++; if (cap_lat[d] !== 6) begin errors++; $display("FAIL rand_latency w%0d it%0d: got %0d want 6", 5+d, it, cap_lat[d]); end
        checks++; if (cap_x[d] !== 7'(ex)) begin errors++; $display("FAIL rand_x w%0d it%0d: got %0d want %0d", 5+d, it, cap_x[d], ex); end
        checks++; if (cap_y[d] !== 7'(ey)) begin errors++; $display("FAIL rand_y w%0d it%0d: got %0d want %0d", 5+d, it, cap_y[d], ey); end
        checks++; if (cap_inf[d] !== ei) begin errors++; $display("FAIL rand_inf w%0d it%0d: got %b want %b", 5+d, it, cap_inf[d], ei); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    pr = 7'(P);
    ca = 7'(A);
    for (int x = 0; x < P; x++) begin
      for (int y = 0; y < P; y++) begin
        if (md(y * y) == md(x * x * x + A * x + B)) begin
          px.push_back(x);
          py.push_back(y);
        end
      end
    end
    test_reset;
    test_add;
    test_double;
    test_inverse;
    test_double_y0;
    test_busy;
    test_reset_mid;
    test_after_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
